lock_supervisor: RTL and testbench



---
 rtl/lock_pkg.sv | 51 +++++
 rtl/lock_timer.sv | 35 +++
 rtl/lock_supervisor.sv | 157 +++++++++++++++
 tb/tb_lock_supervisor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock supervisor:
// state encoding, factory code, progress thermometer codes and key helpers.
package lock_pkg;

    // Entry states sit at 1..3 and PROG states at 8..11, so the low two bits index the code digit.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ENTRY1   = 4'd1,
        ST_ENTRY2   = 4'd2,
        ST_ENTRY3   = 4'd3,
        ST_UNLOCKED = 4'd4,
        ST_LOCKOUT  = 4'd5,
        ST_PROG0    = 4'd8,
        ST_PROG1    = 4'd9,
        ST_PROG2    = 4'd10,
        ST_PROG3    = 4'd11
    } state_t;

    typedef logic [3:0][3:0] code_t;

    localparam code_t DEFAULT_CODE = {4'b0010, 4'b1000, 4'b0100, 4'b0001};

    localparam logic [3:0] THERM_0 = 4'b0000;
    localparam logic [3:0] THERM_1 = 4'b0001;
    localparam logic [3:0] THERM_2 = 4'b0011;
    localparam logic [3:0] THERM_3 = 4'b0111;
    localparam logic [3:0] THERM_4 = 4'b1111;

    function automatic logic onehot4(input logic [3:0] k);
        return (k != 4'b0000) && ((k & (k - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [3:0] progress_of(input state_t s);
        logic [3:0] p;
        case (s)
            ST_ENTRY1, ST_PROG1: p = THERM_1;
            ST_ENTRY2, ST_PROG2: p = THERM_2;
            ST_ENTRY3, ST_PROG3: p = THERM_3;
            ST_UNLOCKED:         p = THERM_4;
            default:             p = THERM_0;
        endcase
        return p;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired_o flags the cycle in which the count reaches zero,
// so a load of N keeps the owning state alive for exactly N cycles.
module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/lock_supervisor.sv
// Keypad code-lock supervisor: 4-key code entry, failure counting with timed lockout,
// auto-relock and in-field code reprogramming. All outputs registered from next state.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 500,
    parameter int ENTRY_TIMEOUT  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keys,
    input  logic       lock_req,
    input  logic       prog_req,
    output logic       unlock,
    output logic [3:0] progress,
    output logic       lockout,
    output logic       prog_mode,
    output logic [3:0] fail_cnt
);

    localparam int TMAX = max3(LOCKOUT_CYCLES, RELOCK_CYCLES, ENTRY_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [3:0] MAX_FAILS_W = 4'(MAX_FAILS);

    state_t state_q, state_d;
    code_t  code_q, code_d;
    code_t  shadow_q, shadow_d;
    logic [3:0] fail_q, fail_d;
    logic [3:0] fail_inc;

    logic       unlock_q, lockout_q, prog_mode_q;
    logic [3:0] progress_q;

    logic          key_ev, key_ok, fail;
    logic          tmr_load, tmr_expired;
    logic [TW-1:0] tmr_value;

    assign key_ev   = (keys != 4'b0000);
    assign key_ok   = onehot4(keys);
    assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        fail_d   = fail_q;
        fail     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_ev) begin
                    if (keys == code_q[0]) state_d = ST_ENTRY1;
                    else                   fail    = 1'b1;
                end
            end
            ST_ENTRY1, ST_ENTRY2, ST_ENTRY3: begin
                // A key in the expiry cycle is evaluated before the timeout.
                if (key_ev) begin
                    if (keys == code_q[state_q[1:0]]) state_d = state_t'(state_q + 4'd1);
                    else                              fail    = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                if (lock_req || tmr_expired) state_d = ST_IDLE;
                else if (prog_req)           state_d = ST_PROG0;
            end
            ST_LOCKOUT: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    fail_d  = 4'd0;
                end
            end
            ST_PROG0, ST_PROG1, ST_PROG2, ST_PROG3: begin
                if (key_ev) begin
                    if (key_ok) begin
                        shadow_d[state_q[1:0]] = keys;
                        if (state_q == ST_PROG3) begin
                            code_d  = {keys, shadow_q[2], shadow_q[1], shadow_q[0]};
                            state_d = ST_IDLE;
                        end else begin
                            state_d = state_t'(state_q + 4'd1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The offending key is consumed by the failure; it never starts a new entry.
        if (fail) begin
            fail_d  = fail_inc;
            state_d = (fail_inc >= MAX_FAILS_W) ? ST_LOCKOUT : ST_IDLE;
        end
        if (state_d == ST_UNLOCKED && state_q != ST_UNLOCKED) begin
            fail_d = 4'd0;
        end
    end

    // Every accepted key also changes state, so a state change is the only reload trigger.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_ENTRY1, ST_ENTRY2, ST_ENTRY3,
            ST_PROG0, ST_PROG1, ST_PROG2, ST_PROG3: tmr_value = TW'(ENTRY_TIMEOUT);
            ST_UNLOCKED:                            tmr_value = TW'(RELOCK_CYCLES);
            ST_LOCKOUT:                             tmr_value = TW'(LOCKOUT_CYCLES);
            default:                                tmr_value = '0;
        endcase
    end

    lock_timer #(
        .W (TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            code_q      <= DEFAULT_CODE;
            shadow_q    <= DEFAULT_CODE;
            fail_q      <= 4'd0;
            unlock_q    <= 1'b0;
            progress_q  <= THERM_0;
            lockout_q   <= 1'b0;
            prog_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            shadow_q    <= shadow_d;
            fail_q      <= fail_d;
            unlock_q    <= (state_d == ST_UNLOCKED);
            progress_q  <= progress_of(state_d);
            lockout_q   <= (state_d == ST_LOCKOUT);
            prog_mode_q <= (state_d == ST_PROG0) || (state_d == ST_PROG1) ||
                           (state_d == ST_PROG2) || (state_d == ST_PROG3);
        end
    end

    assign unlock    = unlock_q;
    assign progress  = progress_q;
    assign lockout   = lockout_q;
    assign prog_mode = prog_mode_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor: a vector table (idle gap, inputs, expected outputs)
// plus hand-written sequences for reset, request priority and programming abort.
module tb_lock_supervisor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys;
    logic       lock_req;
    logic       prog_req;
    logic       unlock;
    logic [3:0] progress;
    logic       lockout;
    logic       prog_mode;
    logic [3:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          pre;
        logic [3:0]  k;
        logic        lr;
        logic        pr;
        logic [10:0] e;
    } vec_t;

    vec_t tbl[$];

    lock_supervisor dut (
        .clk       (clk),
        .reset     (reset),
        .keys      (keys),
        .lock_req  (lock_req),
        .prog_req  (prog_req),
        .unlock    (unlock),
        .progress  (progress),
        .lockout   (lockout),
        .prog_mode (prog_mode),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic u, input logic [3:0] p, input logic l,
                                       input logic pm, input logic [3:0] f);
        return {u, p, l, pm, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [10:0] e);
        logic [10:0] got;
        got = {unlock, progress, lockout, prog_mode, fail_cnt};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (unlock|progress|lockout|prog_mode|fail_cnt)",
                     nm, got, e);
        end
    endtask

    task automatic step(input string nm, input logic [3:0] k, input logic lr, input logic pr,
                        input logic [10:0] e);
        keys = k; lock_req = lr; prog_req = pr;
        tick();
        keys = 4'b0000; lock_req = 1'b0; prog_req = 1'b0;
        check(nm, e);
    endtask

    task automatic add(input int pre, input logic [3:0] k, input logic lr, input logic pr,
                       input logic [10:0] e);
        vec_t v;
        v.pre = pre; v.k = k; v.lr = lr; v.pr = pr; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        logic [10:0] IDLE0;
        IDLE0 = ex(1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);

        // Default code with 3-cycle gaps, then auto-relock after 500 cycles.
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        add(3,   4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 0));
        add(3,   4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 0));
        add(3,   4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(498, 4'b0000, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0000, 0, 0, IDLE0);
        // Three wrong first keys -> lockout; correct code ignored; release after 1000 cycles.
        add(0,   4'b0010, 0, 0, ex(0, 4'b0000, 0, 0, 1));
        add(0,   4'b0010, 0, 0, ex(0, 4'b0000, 0, 0, 2));
        add(0,   4'b0010, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(1,   4'b0100, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(1,   4'b1000, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(1,   4'b0010, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(991, 4'b0000, 0, 0, ex(0, 4'b0000, 1, 0, 3));
        add(0,   4'b0000, 0, 0, IDLE0);
        // Multi-bit key mid-entry is a failure; a full correct entry clears the count.
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        add(0,   4'b0101, 0, 0, ex(0, 4'b0000, 0, 0, 1));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 1));
        add(0,   4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 1));
        add(0,   4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0000, 1, 0, IDLE0);
        // Entry timeout keeps fail_cnt; a key in the expiry cycle still advances.
        add(0,   4'b0010, 0, 0, ex(0, 4'b0000, 0, 0, 1));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 1));
        add(0,   4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(198, 4'b0000, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(0,   4'b0000, 0, 0, ex(0, 4'b0000, 0, 0, 1));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 1));
        add(0,   4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(198, 4'b0000, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 1));
        add(0,   4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0000, 1, 0, IDLE0);
        // Reprogram to 1000,1000,0001,0010; old first key fails, new code unlocks.
        add(0,   4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        add(0,   4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 0));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 0));
        add(0,   4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0100, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0000, 0, 1, ex(0, 4'b0000, 0, 1, 0));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0001, 0, 1, 0));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0011, 0, 1, 0));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0111, 0, 1, 0));
        add(0,   4'b0010, 0, 0, IDLE0);
        add(0,   4'b0001, 0, 0, ex(0, 4'b0000, 0, 0, 1));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0001, 0, 0, 1));
        add(0,   4'b1000, 0, 0, ex(0, 4'b0011, 0, 0, 1));
        add(0,   4'b0001, 0, 0, ex(0, 4'b0111, 0, 0, 1));
        add(0,   4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        add(0,   4'b0000, 1, 0, IDLE0);

        keys = 4'b0000; lock_req = 1'b0; prog_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_values", IDLE0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].pre; j++) tick();
            step($sformatf("vec%0d", i), tbl[i].k, tbl[i].lr, tbl[i].pr, tbl[i].e);
        end

        // Reset restores the factory code.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_after_prog", IDLE0);
        step("dflt_k1", 4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        step("dflt_k2", 4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 0));
        step("dflt_k3", 4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 0));
        step("dflt_k4", 4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        step("lock_beats_prog", 4'b0000, 1, 1, IDLE0);

        // Asynchronous reset while in ENTRY2.
        step("e2_k1", 4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        step("e2_k2", 4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 0));
        #3 reset = 1'b1;
        #1 check("async_reset_entry2", IDLE0);
        tick();
        reset = 1'b0;

        // Invalid key in PROG0 aborts and leaves the code intact.
        step("ab_k1", 4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));
        step("ab_k2", 4'b0100, 0, 0, ex(0, 4'b0011, 0, 0, 0));
        step("ab_k3", 4'b1000, 0, 0, ex(0, 4'b0111, 0, 0, 0));
        step("ab_k4", 4'b0010, 0, 0, ex(1, 4'b1111, 0, 0, 0));
        step("ab_prog", 4'b0000, 0, 1, ex(0, 4'b0000, 0, 1, 0));
        step("prog_abort", 4'b1100, 0, 0, IDLE0);
        step("code_kept", 4'b0001, 0, 0, ex(0, 4'b0001, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
